// File: rtl/video_timing_monitor.sv
// Receive-side raster probe: measures line/frame geometry, sync widths and a CRC-16
// of active pixels per frame, and reports lock/stability and loss-of-hsync timeout.
module video_timing_monitor #(
   parameter int HCNT_W        = 10,
   parameter int VCNT_W        = 10,
   parameter int STABLE_FRAMES = 2
) (
   input  logic              i_clk,
   input  logic              reset,
   input  logic              ce_pixel,
   input  logic              hblank,
   input  logic              vblank,
   input  logic              hsync,
   input  logic              vsync,
   input  logic [3:0]        r,
   input  logic [3:0]        g,
   input  logic [3:0]        b,
   output logic [HCNT_W-1:0] h_total,
   output logic [HCNT_W-1:0] h_active,
   output logic [HCNT_W-1:0] h_sync_w,
   output logic [VCNT_W-1:0] v_total,
   output logic [VCNT_W-1:0] v_active,
   output logic [VCNT_W-1:0] v_sync_w,
   output logic [15:0]       frame_crc,
   output logic              frame_valid,
   output logic              locked,
   output logic              timeout
);

   typedef enum logic [1:0] {S_DISARMED = 2'd0, S_ARMED = 2'd1, S_RUN = 2'd2} state_t;

   localparam logic [HCNT_W-1:0] HC_MAX   = '1;
   localparam logic [3:0]        STAB_MIN = 4'(STABLE_FRAMES - 1);

   state_t state_q, state_d;

   logic              hs_prev_q, hs_prev_d, hb_prev_q, hb_prev_d, vs_prev_q, vs_prev_d;
   logic [HCNT_W-1:0] hc_q, hc_d, hsc_q, hsc_d, hac_q, hac_d;
   logic [HCNT_W-1:0] line_tot_q, line_tot_d, hsync_sh_q, hsync_sh_d, h_act_sh_q, h_act_sh_d;
   logic [VCNT_W-1:0] vc_q, vc_d, vac_q, vac_d, vsc_q, vsc_d, vsync_sh_q, vsync_sh_d;
   logic [15:0]       crc_q, crc_d;
   logic [HCNT_W-1:0] h_total_q, h_total_d, h_active_q, h_active_d, h_sync_w_q, h_sync_w_d;
   logic [VCNT_W-1:0] v_total_q, v_total_d, v_active_q, v_active_d, v_sync_w_q, v_sync_w_d;
   logic [15:0]       frame_crc_q, frame_crc_d;
   logic              frame_valid_q, frame_valid_d, timeout_q, timeout_d;
   logic [3:0]        stab_q, stab_d;

   logic hs_rise, hs_fall, hb_rise, vs_rise, vs_fall, to_hit, publish;

   function automatic logic [HCNT_W-1:0] hinc(input logic [HCNT_W-1:0] x);
      return (x == '1) ? x : x + 1'b1;
   endfunction

   function automatic logic [VCNT_W-1:0] vinc(input logic [VCNT_W-1:0] x);
      return (x == '1) ? x : x + 1'b1;
   endfunction

   // CCITT 0x1021, 12 bits per pixel, MSB first
   function automatic logic [15:0] crc12(input logic [15:0] c, input logic [11:0] d);
      logic [15:0] x;
      x = c;
      for (int i = 11; i >= 0; i--)
         x = {x[14:0], 1'b0} ^ ((x[15] ^ d[i]) ? 16'h1021 : 16'h0000);
      return x;
   endfunction

   always_comb begin
      hs_rise = ce_pixel &  hsync  & ~hs_prev_q;
      hs_fall = ce_pixel & ~hsync  &  hs_prev_q;
      hb_rise = ce_pixel &  hblank & ~hb_prev_q;
      vs_rise = ce_pixel &  vsync  & ~vs_prev_q;
      vs_fall = ce_pixel & ~vsync  &  vs_prev_q;
      // hc would land on all-ones this pixel with no hsync to restart it
      to_hit  = ce_pixel & ~hs_rise & (hc_q >= HC_MAX - 1'b1);
      publish = vs_rise & ~to_hit & (state_q != S_DISARMED);
   end

   // FSM: state register
   always_ff @(posedge i_clk or posedge reset) begin
      if (reset) state_q <= S_DISARMED;
      else       state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      if (to_hit)
         state_d = S_DISARMED;
      else if (vs_rise)
         state_d = (state_q == S_DISARMED) ? S_ARMED : S_RUN;
   end

   // FSM: outputs
   always_comb begin
      locked = (state_q == S_RUN) && !timeout_q && (stab_q >= STAB_MIN);
   end

   always_comb begin
      hs_prev_d = hs_prev_q;  hb_prev_d = hb_prev_q;  vs_prev_d = vs_prev_q;
      hc_d = hc_q;  hsc_d = hsc_q;  hac_d = hac_q;
      line_tot_d = line_tot_q;  hsync_sh_d = hsync_sh_q;  h_act_sh_d = h_act_sh_q;
      vc_d = vc_q;  vac_d = vac_q;  vsc_d = vsc_q;  vsync_sh_d = vsync_sh_q;
      crc_d = crc_q;
      h_total_d = h_total_q;  h_active_d = h_active_q;  h_sync_w_d = h_sync_w_q;
      v_total_d = v_total_q;  v_active_d = v_active_q;  v_sync_w_d = v_sync_w_q;
      frame_crc_d = frame_crc_q;
      frame_valid_d = 1'b0;
      timeout_d = timeout_q;
      stab_d = stab_q;

      if (ce_pixel) begin
         hs_prev_d = hsync;  hb_prev_d = hblank;  vs_prev_d = vsync;
         hc_d = hs_rise ? HCNT_W'(1) : hinc(hc_q);
         if (hs_rise) begin
            line_tot_d = hc_q;
            vc_d       = vinc(vc_q);
         end
         if (hs_fall) begin
            hsync_sh_d = hsc_q;
            hsc_d      = '0;
         end else if (hsync) hsc_d = hinc(hsc_q);
         if (hb_rise) begin
            if (!vblank) begin
               h_act_sh_d = hac_q;
               vac_d      = vinc(vac_q);
            end
            hac_d = '0;
         end else if (!hblank) hac_d = hinc(hac_q);
         if (vs_fall) begin
            vsync_sh_d = vsc_q;
            vsc_d      = '0;
         end else if (vsync && hs_rise) vsc_d = vinc(vsc_q);
         if (!hblank && !vblank) crc_d = crc12(crc_q, {r, g, b});
         if (hs_rise) timeout_d = 1'b0;
         else if (to_hit) begin
            timeout_d = 1'b1;
            stab_d    = '0;
         end
      end

      // publish uses this pixel's updates so a coincident hsync rise closes the old frame
      if (publish) begin
         h_total_d  = line_tot_d;  h_active_d = h_act_sh_d;  h_sync_w_d = hsync_sh_d;
         v_total_d  = vc_d;        v_active_d = vac_d;       v_sync_w_d = vsync_sh_d;
         frame_crc_d   = crc_d;
         frame_valid_d = 1'b1;
         if (state_q == S_RUN && line_tot_d == h_total_q && h_act_sh_d == h_active_q &&
             vc_d == v_total_q && vac_d == v_active_q)
            stab_d = (stab_q == 4'hF) ? stab_q : stab_q + 4'd1;
         else
            stab_d = '0;
      end
      if (vs_rise && !to_hit) begin
         vc_d  = '0;
         vac_d = '0;
         crc_d = 16'hFFFF;
      end
   end

   always_ff @(posedge i_clk or posedge reset) begin
      if (reset) begin
         hs_prev_q <= 1'b0;  hb_prev_q <= 1'b0;  vs_prev_q <= 1'b0;
         hc_q <= '0;  hsc_q <= '0;  hac_q <= '0;
         line_tot_q <= '0;  hsync_sh_q <= '0;  h_act_sh_q <= '0;
         vc_q <= '0;  vac_q <= '0;  vsc_q <= '0;  vsync_sh_q <= '0;
         crc_q <= 16'hFFFF;
         h_total_q <= '0;  h_active_q <= '0;  h_sync_w_q <= '0;
         v_total_q <= '0;  v_active_q <= '0;  v_sync_w_q <= '0;
         frame_crc_q <= '0;  frame_valid_q <= 1'b0;  timeout_q <= 1'b0;  stab_q <= '0;
      end else begin
         hs_prev_q <= hs_prev_d;  hb_prev_q <= hb_prev_d;  vs_prev_q <= vs_prev_d;
         hc_q <= hc_d;  hsc_q <= hsc_d;  hac_q <= hac_d;
         line_tot_q <= line_tot_d;  hsync_sh_q <= hsync_sh_d;  h_act_sh_q <= h_act_sh_d;
         vc_q <= vc_d;  vac_q <= vac_d;  vsc_q <= vsc_d;  vsync_sh_q <= vsync_sh_d;
         crc_q <= crc_d;
         h_total_q <= h_total_d;  h_active_q <= h_active_d;  h_sync_w_q <= h_sync_w_d;
         v_total_q <= v_total_d;  v_active_q <= v_active_d;  v_sync_w_q <= v_sync_w_d;
         frame_crc_q <= frame_crc_d;  frame_valid_q <= frame_valid_d;
         timeout_q <= timeout_d;  stab_q <= stab_d;
      end
   end

   assign h_total     = h_total_q;
   assign h_active    = h_active_q;
   assign h_sync_w    = h_sync_w_q;
   assign v_total     = v_total_q;
   assign v_active    = v_active_q;
   assign v_sync_w    = v_sync_w_q;
   assign frame_crc   = frame_crc_q;
   assign frame_valid = frame_valid_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_video_timing_monitor.sv
// Directed bench for video_timing_monitor: a reduced synthetic raster with ce every
// other clock and random garbage on all video inputs while ce is low.
module tb_video_timing_monitor;

   localparam int H_TOT = 48, H_SW = 6, H_BS = 8, H_ACT = 32;
   localparam int V_TOT = 20, V_SW = 3, V_BS = 4, V_ACT = 14;

   logic        i_clk = 1'b0;
   logic        reset = 1'b1;
   logic        ce_pixel = 1'b0;
   logic        hblank = 1'b0, vblank = 1'b0, hsync = 1'b0, vsync = 1'b0;
   logic [3:0]  r = '0, g = '0, b = '0;
   logic [9:0]  h_total, h_active, h_sync_w, v_total, v_active, v_sync_w;
   logic [15:0] frame_crc;
   logic        frame_valid, locked, timeout;

   int n_chk = 0, n_err = 0, fv_cnt = 0, fv_mark = 0;
   logic [15:0] crc_base, crc_flip;

   video_timing_monitor #(.HCNT_W(10), .VCNT_W(10), .STABLE_FRAMES(2)) dut (
      .i_clk(i_clk), .reset(reset), .ce_pixel(ce_pixel),
      .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
      .r(r), .g(g), .b(b),
      .h_total(h_total), .h_active(h_active), .h_sync_w(h_sync_w),
      .v_total(v_total), .v_active(v_active), .v_sync_w(v_sync_w),
      .frame_crc(frame_crc), .frame_valid(frame_valid), .locked(locked), .timeout(timeout)
   );

   always #5 i_clk = ~i_clk;

   always @(negedge i_clk) if (frame_valid === 1'b1) fv_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] pix(input int l, input int p, input int fl, input int fp);
      logic [11:0] v;
      v = 12'(l * 37 + p * 11 + 5);
      if (l == fl && p == fp) v[0] = ~v[0];
      return v;
   endfunction

   function automatic logic [15:0] model_crc(input bit blank, input int fl, input int fp);
      logic [15:0] c;
      logic [11:0] d;
      logic        fb;
      c = 16'hFFFF;
      if (blank) return c;
      for (int l = V_BS; l < V_BS + V_ACT; l++)
         for (int p = H_BS; p < H_BS + H_ACT; p++) begin
            d = pix(l, p, fl, fp);
            for (int i = 11; i >= 0; i--) begin
               fb = c[15] ^ d[i];
               c  = c << 1;
               if (fb) c = c ^ 16'h1021;
            end
         end
      return c;
   endfunction

   task automatic px(input logic hs, input logic hb, input logic vs, input logic vb,
                     input logic [11:0] rgb);
      @(negedge i_clk);
      hsync = hs;  hblank = hb;  vsync = vs;  vblank = vb;  {r, g, b} = rgb;
      ce_pixel = 1'b1;
      @(negedge i_clk);
      ce_pixel = 1'b0;
      {hsync, hblank, vsync, vblank} = 4'($urandom);
      {r, g, b} = 12'($urandom);
   endtask

   task automatic raster_px(input int l, input int p, input bit blank, input int fl, input int fp);
      px(p < H_SW, !(p >= H_BS && p < H_BS + H_ACT), l < V_SW,
         blank || !(l >= V_BS && l < V_BS + V_ACT), pix(l, p, fl, fp));
   endtask

   task automatic send_frame(input int htot, input bit blank, input int fl, input int fp);
      fv_mark = fv_cnt;
      for (int l = 0; l < V_TOT; l++)
         for (int p = 0; p < htot; p++) raster_px(l, p, blank, fl, fp);
   endtask

   task automatic chk_pub(input string tag, input int htot, input int vact,
                          input logic [15:0] crc, input logic lk);
      check({tag, ".fv"},       fv_cnt - fv_mark, 1);
      check({tag, ".h_total"},  h_total, htot);
      check({tag, ".h_active"}, h_active, H_ACT);
      check({tag, ".h_sync_w"}, h_sync_w, H_SW);
      check({tag, ".v_total"},  v_total, V_TOT);
      check({tag, ".v_active"}, v_active, vact);
      check({tag, ".v_sync_w"}, v_sync_w, V_SW);
      check({tag, ".crc"},      frame_crc, crc);
      check({tag, ".locked"},   locked, lk);
   endtask

   task automatic chk_zero(input string tag);
      check({tag, ".h_total"}, h_total, 0);
      check({tag, ".h_active"}, h_active, 0);
      check({tag, ".h_sync_w"}, h_sync_w, 0);
      check({tag, ".v_total"}, v_total, 0);
      check({tag, ".v_active"}, v_active, 0);
      check({tag, ".v_sync_w"}, v_sync_w, 0);
      check({tag, ".crc"}, frame_crc, 0);
      check({tag, ".fv"}, frame_valid, 0);
      check({tag, ".locked"}, locked, 0);
      check({tag, ".timeout"}, timeout, 0);
   endtask

   initial begin
      crc_base = model_crc(1'b0, -1, -1);
      crc_flip = model_crc(1'b0, V_BS + 5, H_BS + 7);
      repeat (4) @(negedge i_clk);
      chk_zero("rst");
      reset = 1'b0;
      repeat (2) @(negedge i_clk);
      chk_zero("post_rst");

      // first vsync rise only arms
      send_frame(H_TOT, 0, -1, -1);
      check("arm.fv", fv_cnt - fv_mark, 0);
      send_frame(H_TOT, 0, -1, -1);
      chk_pub("f0", H_TOT, V_ACT, crc_base, 1'b0);
      send_frame(H_TOT, 0, -1, -1);
      chk_pub("f1", H_TOT, V_ACT, crc_base, 1'b1);

      // one long-line frame breaks lock; two clean frames restore it
      send_frame(H_TOT + 1, 0, -1, -1);
      chk_pub("f2", H_TOT, V_ACT, crc_base, 1'b1);
      send_frame(H_TOT, 0, -1, -1);
      check("f3.h_total", h_total, H_TOT + 1);
      check("f3.locked", locked, 0);
      send_frame(H_TOT, 0, -1, -1);
      chk_pub("f4", H_TOT, V_ACT, crc_base, 1'b0);
      send_frame(H_TOT, 0, V_BS + 5, H_BS + 7);
      chk_pub("f5", H_TOT, V_ACT, crc_base, 1'b1);
      send_frame(H_TOT, 1, -1, -1);
      chk_pub("f6_flip", H_TOT, V_ACT, crc_flip, 1'b1);
      check("flip_differs", frame_crc != crc_base, 1);
      send_frame(H_TOT, 0, -1, -1);
      chk_pub("f7_blank", H_TOT, 0, 16'hFFFF, 1'b0);
      send_frame(H_TOT, 0, -1, -1);
      chk_pub("f8", H_TOT, V_ACT, crc_base, 1'b0);
      send_frame(H_TOT, 0, -1, -1);
      chk_pub("f9", H_TOT, V_ACT, crc_base, 1'b1);

      // hsync stops: hc reaches 1023 on the 975th idle pixel
      fv_mark = fv_cnt;
      for (int i = 0; i < 974; i++) px(1'b0, 1'b1, 1'b0, 1'b1, 12'h000);
      check("to_pre.timeout", timeout, 0);
      check("to_pre.locked", locked, 1);
      px(1'b0, 1'b1, 1'b0, 1'b1, 12'h000);
      check("to.timeout", timeout, 1);
      check("to.locked", locked, 0);
      for (int i = 0; i < 20; i++) px(1'b0, 1'b1, 1'b0, 1'b1, 12'h000);
      check("to_hold.timeout", timeout, 1);
      check("to.fv", fv_cnt - fv_mark, 0);

      // resync line, then one frame to re-arm before publishes resume
      px(1'b1, 1'b1, 1'b0, 1'b1, 12'h000);
      check("resync.timeout", timeout, 0);
      for (int p = 1; p < H_TOT; p++) px(p < H_SW, 1'b1, 1'b0, 1'b1, 12'h000);
      send_frame(H_TOT, 0, -1, -1);
      check("rearm.fv", fv_cnt - fv_mark, 0);
      send_frame(H_TOT, 0, -1, -1);
      chk_pub("r0", H_TOT, V_ACT, crc_base, 1'b0);
      send_frame(H_TOT, 0, -1, -1);
      chk_pub("r1", H_TOT, V_ACT, crc_base, 1'b1);

      // reset mid-line during a locked run
      fv_mark = fv_cnt;
      for (int p = 0; p < 20; p++) raster_px(0, p, 0, -1, -1);
      chk_pub("r2", H_TOT, V_ACT, crc_base, 1'b1);
      @(negedge i_clk);
      reset = 1'b1;
      #1;
      chk_zero("mid_rst");
      repeat (3) @(negedge i_clk);
      reset = 1'b0;
      send_frame(H_TOT, 0, -1, -1);
      check("p_arm.fv", fv_cnt - fv_mark, 0);
      send_frame(H_TOT, 0, -1, -1);
      chk_pub("p0", H_TOT, V_ACT, crc_base, 1'b0);

      // ce low with inputs toggling: nothing may move
      fv_mark = fv_cnt;
      for (int i = 0; i < 200; i++) begin
         @(negedge i_clk);
         {hsync, hblank, vsync, vblank} = 4'($urandom);
         {r, g, b} = 12'($urandom);
      end
      check("ce0.fv", fv_cnt - fv_mark, 0);
      check("ce0.h_total", h_total, H_TOT);
      check("ce0.v_total", v_total, V_TOT);
      check("ce0.timeout", timeout, 0);
      send_frame(H_TOT, 0, -1, -1);
      chk_pub("p1", H_TOT, V_ACT, crc_base, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/video_timing_monitor.md
Name: video_timing_monitor

Overview:
- Receive-side checker for the core's video output: consumes CE_PIXEL, HBLANK, VBLANK, HSYNC, VSYNC and the 4-bit R/G/B that the core drives.
- Measures per-frame raster geometry, sync widths and a CRC of active pixels.
- Flags lock, stability and timeout.
- Sits beside the core top level; read by scaler/OSD logic and by the verification bench as a golden raster probe.

Parameters:
- HCNT_W, 10, width of horizontal counters (pixels per line, saturating)
- VCNT_W, 10, width of vertical counters (lines per frame, saturating)
- STABLE_FRAMES, 2, consecutive identical frames required to assert locked (1..15)

Ports:
- i_clk  in  1  system clock (53.6 MHz)
- reset  in  1  asynchronous, active-high reset
- ce_pixel  in  1  pixel clock enable; all inputs sampled only when high
- hblank  in  1  horizontal blank
- vblank  in  1  vertical blank
- hsync  in  1  horizontal sync, active high
- vsync  in  1  vertical sync, active high
- r, g, b  in  4 each  pixel colour
- h_total  out  HCNT_W  pixels per line
- h_active  out  HCNT_W  non-blanked pixels per active line
- h_sync_w  out  HCNT_W  HSYNC high width, pixels
- v_total  out  VCNT_W  lines per frame
- v_active  out  VCNT_W  active lines per frame
- v_sync_w  out  VCNT_W  VSYNC high width, lines
- frame_crc  out  16  CRC-16 of previous frame's active pixels
- frame_valid  out  1  one-i_clk pulse when outputs update
- locked  out  1  geometry stable
- timeout  out  1  no HSYNC edge within 2^HCNT_W-1 pixels

Behaviour:
- Clocking: one clock, i_clk. Reset is asynchronous and active-high. Reset clears all outputs to 0, clears all internal counters and previous-input registers, and disarms the frame machine. Reset asserted mid-frame discards the partial measurement.
- Edge detection: each input has a previous-value register updated only on ce_pixel. A rise is prev=0 and now=1, evaluated on a ce_pixel cycle. No activity happens when ce_pixel=0.
- Horizontal counting:
  - hc increments on each ce_pixel.
  - On hsync rise: line_tot_sh <= hc; hc <= 1.
  - hsc counts ce while hsync=1. On hsync fall: hsync_sh <= hsc; hsc <= 0.
  - hac counts ce with hblank=0. On hblank rise: if vblank=0, h_act_sh <= hac; hac <= 0 unconditionally.
- Vertical counting:
  - On hsync rise, vc increments.
  - On hblank rise with vblank=0, vac increments.
  - While vsync=1, each hsync rise increments vsc. On vsync fall: vsync_sh <= vsc; vsc <= 0.
- CRC:
  - Polynomial 0x1021 (CCITT), init 0xFFFF.
  - On each ce with hblank=0 and vblank=0, the 12 bits {r,g,b} are shifted in MSB first, all within one clock.
- Frame boundary (vsync rise): FSM states DISARMED -> ARMED -> RUN.
  - DISARMED: the first vsync rise clears vc, vac and the CRC, then moves to ARMED. No outputs are published.
  - ARMED/RUN: each vsync rise publishes, registered and visible the next i_clk:
    - h_total = line_tot_sh, h_active = h_act_sh, h_sync_w = hsync_sh
    - v_total = vc, v_active = vac, v_sync_w = vsync_sh
    - frame_crc = current CRC
  - Same edge: frame_valid pulses for one i_clk; vc, vac and CRC restart (vc <= 0, then counting resumes).
- Simultaneous hsync rise and vsync rise on the same ce: the hsync rise is counted into the closing frame's vc before the publish.
- Stability:
  - At each publish, the new tuple (h_total, h_active, v_total, v_active) is compared with the previously published tuple.
  - Match increments stab_cnt, saturating at 15. Mismatch clears stab_cnt.
  - locked = (stab_cnt >= STABLE_FRAMES-1) and state RUN and !timeout.
  - The first publish after ARMED moves the FSM to RUN with stab_cnt=0.
- Saturation and timeout:
  - All counters saturate at all-ones; they never wrap.
  - If hc reaches 2^HCNT_W-1, timeout=1, locked=0 and the FSM returns to DISARMED.
  - timeout clears on the next hsync rise.
- frame_crc does not affect locked.

Test Plan:
- Synthetic raster, ce every 8 i_clk: 384 px/line, hblank low for 256, hsync 32 px; 264 lines, vblank low for 224 lines, vsync 8 lines. Required: second vsync rise gives frame_valid with h_total=384, h_active=256, h_sync_w=32, v_total=264, v_active=224, v_sync_w=8; locked=0.
- Same raster for 3 frames with STABLE_FRAMES=2 -> locked=1 after third vsync rise. Frame 4 with 385 px/line -> locked=0 at that publish; locked reasserts after frame 6.
- Two frames of identical RGB -> equal frame_crc. Flip one pixel's b[0] -> different frame_crc. All-blank frame (vblank high throughout) -> frame_crc=0xFFFF.
- Stop hsync for 1023 ce -> timeout=1, locked=0. Restart raster -> timeout clears on first hsync rise; one full frame passes with no frame_valid (re-arm), then publishes resume.
- Assert reset for 3 i_clk mid-line during a locked run -> all outputs 0 immediately (async). First post-reset vsync rise produces no frame_valid; the second produces correct values.
- Hold ce_pixel=0 while toggling all sync inputs -> no counter or output change.
